// File: rtl/m72_irq_pkg.sv
// m72_irq_pkg: shared types and constants for the M72 interrupt controller.
//   irq_sel_t : which source a handshake is delivering (or spurious)
//   state_t   : INTA handshake state
//   VEC_OFF_* : low three vector bits per source (IR0 / IR2 / spurious IR7)
//   REG_*     : register select values for A0
package m72_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_VBLANK   = 2'd0,
    IRQ_RASTER   = 2'd1,
    IRQ_SPURIOUS = 2'd2
  } irq_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FROZEN = 2'd1,
    ST_DRIVE  = 2'd2
  } state_t;

  localparam logic [2:0] VEC_OFF_VBLANK   = 3'b000;
  localparam logic [2:0] VEC_OFF_RASTER   = 3'b010;
  localparam logic [2:0] VEC_OFF_SPURIOUS = 3'b111;

  localparam logic REG_BASE = 1'b0;
  localparam logic REG_MASK = 1'b1;

  // Low vector bits for a selected source.
  function automatic logic [2:0] vec_offset(input irq_sel_t sel);
    case (sel)
      IRQ_VBLANK: vec_offset = VEC_OFF_VBLANK;
      IRQ_RASTER: vec_offset = VEC_OFF_RASTER;
      default:    vec_offset = VEC_OFF_SPURIOUS;
    endcase
  endfunction

endpackage

// File: rtl/m72_irq_edge.sv
// m72_irq_edge: rising-edge detector feeding one pending bit.
//   clk, reset : clock and synchronous active-high reset
//   level      : source level (VBLK or HINT)
//   mask_next  : mask value that takes effect at this clock edge
//   clear      : acknowledge clear of the pending bit
//   pending    : registered pending request
module m72_irq_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic mask_next,
  input  logic clear,
  output logic pending
);

  logic prev;
  logic set;

  // A new edge wins over a simultaneous acknowledge clear; a masked source
  // drops both the edge and anything already pending, so unmasking later
  // never raises a stale request.
  assign set = level & ~prev & ~mask_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev    <= level;
      pending <= set | (pending & ~clear & ~mask_next);
    end
  end

endmodule

// File: rtl/m72_irq_ctrl.sv
// m72_irq_ctrl: prioritised, maskable, vectored interrupt controller for the
// V30, fed by the video timing generator. Auto-EOI, two-cycle INTA.
//   CLK_32M      : system clock
//   reset        : synchronous active-high reset
//   VBLK, HINT   : vblank level / raster match from the timing generator
//   WR, A0, DIN  : register write (A0=0 base vector, A0=1 mask)
//   INTA         : one-cycle strobe per CPU INTA bus cycle
//   INTR         : registered interrupt request
//   VECTOR       : registered vector byte, held until the next delivery
//   VECTOR_VALID : one-cycle qualifier for VECTOR
//   fsm_state    : handshake state, for debug observation
//
// Handshake: the first INTA sampled in IDLE latches the winning source; the
// second INTA loads VECTOR, and VECTOR_VALID is high for exactly the one
// cycle spent in DRIVE. There is no back-pressure; INTA seen in DRIVE is
// ignored.
module m72_irq_ctrl
  import m72_irq_pkg::*;
#(
  parameter logic [7:0] BASE_RESET = 8'h20,
  parameter logic [1:0] MASK_RESET = 2'b11
) (
  input  logic       CLK_32M,
  input  logic       reset,
  input  logic       VBLK,
  input  logic       HINT,
  input  logic       WR,
  input  logic       A0,
  input  logic [7:0] DIN,
  input  logic       INTA,
  output logic       INTR,
  output logic [7:0] VECTOR,
  output logic       VECTOR_VALID,
  output state_t     fsm_state
);

  state_t     state, state_next;
  irq_sel_t   sel, sel_next;
  logic       intr_next;
  logic       load_vec;
  logic [7:0] base;
  logic [1:0] mask;
  logic [1:0] mask_next;
  logic [1:0] pending;
  logic [1:0] req;
  logic [1:0] clear;
  logic       hint_lvl;

  assign hint_lvl = HINT;

  // Only base[7:3] reaches the vector; the low bits are stored but unused.
  logic unused_base_bits;
  assign unused_base_bits = ^base[2:0];

  // A mask write takes effect on the same clock edge as any edge arriving
  // with it, and clears pending bits that become masked.
  assign mask_next = (WR && (A0 == REG_MASK)) ? DIN[1:0] : mask;
  assign req       = pending & ~mask;

  assign clear[0] = (state == ST_DRIVE) && (sel == IRQ_VBLANK);
  assign clear[1] = (state == ST_DRIVE) && (sel == IRQ_RASTER);

  m72_irq_edge u_edge_vblk (
    .clk       (CLK_32M),
    .reset     (reset),
    .level     (VBLK),
    .mask_next (mask_next[0]),
    .clear     (clear[0]),
    .pending   (pending[0])
  );

  m72_irq_edge u_edge_hint (
    .clk       (CLK_32M),
    .reset     (reset),
    .level     (hint_lvl),
    .mask_next (mask_next[1]),
    .clear     (clear[1]),
    .pending   (pending[1])
  );

  always_comb begin
    state_next = state;
    sel_next   = sel;
    intr_next  = INTR;
    load_vec   = 1'b0;
    case (state)
      ST_IDLE: begin
        intr_next = |req;
        if (INTA) begin
          state_next = ST_FROZEN;
          if (req[0])      sel_next = IRQ_VBLANK;
          else if (req[1]) sel_next = IRQ_RASTER;
          else             sel_next = IRQ_SPURIOUS;
        end
      end
      ST_FROZEN: begin
        // INTR holds; sel is frozen even if its source is masked meanwhile.
        if (INTA) begin
          state_next = ST_DRIVE;
          load_vec   = 1'b1;
        end
      end
      ST_DRIVE: begin
        // Keep INTR up only if something other than the source being
        // acknowledged is still requesting.
        state_next = ST_IDLE;
        intr_next  = |(req & ~clear);
      end
      default: begin
        state_next = ST_IDLE;
        intr_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state        <= ST_IDLE;
      sel          <= IRQ_SPURIOUS;
      INTR         <= 1'b0;
      VECTOR       <= 8'h00;
      VECTOR_VALID <= 1'b0;
      base         <= BASE_RESET;
      mask         <= MASK_RESET;
    end else begin
      state        <= state_next;
      sel          <= sel_next;
      INTR         <= intr_next;
      VECTOR_VALID <= load_vec;
      mask         <= mask_next;
      if (load_vec) VECTOR <= {base[7:3], vec_offset(sel)};
      if (WR && (A0 == REG_BASE)) base <= DIN;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_m72_irq_ctrl.sv
// Bench for m72_irq_ctrl: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the controller.
module tb_m72_irq_ctrl;
  import m72_irq_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset, vblk, hint_line, wr, a0, inta;
  logic [7:0] din;
  logic       intr, vector_valid;
  logic [7:0] vector;
  state_t     fsm_state;

  always #5 clk = ~clk;

  m72_irq_ctrl dut (
    .CLK_32M      (clk),
    .reset        (reset),
    .VBLK         (vblk),
    .HINT         (hint_line),
    .WR           (wr),
    .A0           (a0),
    .DIN          (din),
    .INTA         (inta),
    .INTR         (intr),
    .VECTOR       (vector),
    .VECTOR_VALID (vector_valid),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic       intr;
    logic       valid;
    logic [7:0] vec;
    logic       chk_idle;
  } cyc_t;

  cyc_t       cyc_q[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       cur_v = 1'b0;
  logic       cur_h = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // acks: number of INTA strobes accepted in the current acknowledge
  // (0 = waiting, 1 = source chosen, 2 = delivering this cycle).
  logic [1:0] m_pend, m_mask;
  logic [7:0] m_base, m_vec;
  logic       m_intr, m_prev_v, m_prev_h;
  int         m_acks, m_src;   // m_src: 0 vblank, 1 raster, 2 spurious

  function automatic logic [7:0] model_vector(input logic [7:0] b, input int src);
    logic [7:0] low;
    if (src == 0)      low = 8'd0;
    else if (src == 1) low = 8'd2;
    else               low = 8'd7;
    return (b & 8'hF8) | low;
  endfunction

  // Predicts the DUT's registered outputs after the coming clock edge.
  task automatic model_step(input logic r, input logic v, input logic h,
                            input logic w, input logic sel_a0, input logic [7:0] d,
                            input logic ack);
    cyc_t       e;
    logic [1:0] want, new_mask, edges;
    logic       n_intr, n_valid;
    if (r) begin
      m_pend = 2'b00; m_mask = 2'b11; m_base = 8'h20; m_vec = 8'h00;
      m_intr = 1'b0; m_prev_v = 1'b0; m_prev_h = 1'b0; m_acks = 0; m_src = 2;
      e.intr = 1'b0; e.valid = 1'b0; e.vec = 8'h00; e.chk_idle = 1'b1;
      cyc_q.push_back(e);
      return;
    end
    want     = m_pend & ~m_mask;
    new_mask = (w && sel_a0) ? d[1:0] : m_mask;
    edges    = {h && !m_prev_h, v && !m_prev_v};
    n_valid  = (m_acks == 1) && ack;
    if (m_acks == 0)      n_intr = (want != 2'b00);
    else if (m_acks == 1) n_intr = m_intr;
    else begin
      if (m_src < 2) want[m_src] = 1'b0;
      n_intr = (want != 2'b00);
      want   = m_pend & ~m_mask;
    end
    if (n_valid) begin
      m_vec = model_vector(m_base, m_src);
      exp_q.push_back(m_vec);
    end
    for (int i = 0; i < 2; i++) begin
      if (m_acks == 2 && m_src == i) m_pend[i] = 1'b0;
      if (new_mask[i])               m_pend[i] = 1'b0;
      if (edges[i] && !new_mask[i])  m_pend[i] = 1'b1;
    end
    if (m_acks == 0 && ack) begin
      m_acks = 1;
      m_src  = want[0] ? 0 : (want[1] ? 1 : 2);
    end else if (m_acks == 1 && ack) m_acks = 2;
    else if (m_acks == 2)           m_acks = 0;
    if (w && !sel_a0) m_base = d;
    m_mask = new_mask; m_prev_v = v; m_prev_h = h; m_intr = n_intr;
    e.intr = n_intr; e.valid = n_valid; e.vec = m_vec; e.chk_idle = 1'b0;
    cyc_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs (called away from the rising edge).
  task automatic step(input logic r, input logic w, input logic sel_a0,
                      input logic [7:0] d, input logic ack);
    reset = r; vblk = cur_v; hint_line = cur_h; wr = w; a0 = sel_a0; din = d; inta = ack;
    model_step(r, cur_v, cur_h, w, sel_a0, d, ack);
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr_reg(input logic sel_a0, input logic [7:0] d);
    step(1'b0, 1'b1, sel_a0, d, 1'b0);
  endtask

  task automatic ack_pulse();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic handshake();
    ack_pulse(); cyc(1); ack_pulse(); cyc(2);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    cyc_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("intr", 32'(intr), 32'(e.intr));
        check("vector_valid", 32'(vector_valid), 32'(e.valid));
        check("vector_hold", 32'(vector), 32'(e.vec));
        if (e.chk_idle) check("state_after_reset", 32'(fsm_state), 32'(ST_IDLE));
      end
      if (vector_valid === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_vector", 32'(vector), 32'hFFFF_FFFF);
        else                   check("vector", 32'(vector), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset(2);

    // 1: single vblank edge, base 0x40
    wr_reg(1'b1, 8'h00); wr_reg(1'b0, 8'h40);
    cur_v = 1'b1; cyc(3);
    handshake();
    cur_v = 1'b0; cyc(2);

    // 2: simultaneous vblank and raster, base 0x20
    wr_reg(1'b0, 8'h20);
    cur_v = 1'b1; cur_h = 1'b1; cyc(3);
    handshake(); handshake();
    cur_v = 1'b0; cur_h = 1'b0; cyc(2);

    // 3: masked raster edge is not retroactive
    wr_reg(1'b1, 8'h02);
    cur_h = 1'b1; cyc(3);
    wr_reg(1'b1, 8'h00); cyc(3);
    cur_h = 1'b0; cyc(1);

    // 4: mask clears pending raster; later acknowledge is spurious
    cur_h = 1'b1; cyc(3);
    wr_reg(1'b1, 8'h02); cyc(2);
    handshake();
    cur_h = 1'b0; wr_reg(1'b1, 8'h00); cyc(1);

    // 5: vblank arrives while raster acknowledge is frozen
    cur_h = 1'b1; cyc(3);
    ack_pulse(); cur_v = 1'b1; cyc(1); ack_pulse(); cyc(3);
    handshake();
    cur_v = 1'b0; cur_h = 1'b0; cyc(2);

    // 6: reset between the two INTA strobes
    cur_v = 1'b1; cyc(3);
    ack_pulse(); cyc(1);
    do_reset(1); cyc(1);
    cur_v = 1'b0; cyc(1); cur_v = 1'b1; cyc(3);   // still masked after reset
    wr_reg(1'b1, 8'h00);
    cur_v = 1'b0; cyc(1); cur_v = 1'b1; cyc(3);
    handshake();                                  // base back at 0x20
    cur_v = 1'b0; cyc(2);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic       r, w, s, k;
      logic [7:0] d;
      if ($urandom_range(0, 3) == 0) cur_v = ~cur_v;
      if ($urandom_range(0, 3) == 0) cur_h = ~cur_h;
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 7) == 0);
      s = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      k = ($urandom_range(0, 3) == 0);
      step(r, w, s, d, k);
    end
    cyc(3);
    @(negedge clk);

    check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    check("vector_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
